// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared AXI definitions for the DMA read/write outstanding-burst FIFOs.
//   - addr_32_t / addr_64_t : byte address types
//   - trans_32_t / trans_64_t : burst descriptor {start_addr, len}, where len
//     is the beat count (1..AXI_BURST_MAX)
//   - AXI_BURST_MAX : longest burst in beats (AXI4 INCR limit)
//   - AXI_4K_BYTES : address boundary a burst may never cross
//   - RRESP_* : read response encodings
//   - min_u32 : unsigned minimum helper used by the burst splitter
// -----------------------------------------------------------------------------
package axi_pkg;

  localparam int AXI_BURST_MAX = 256;
  // Beat count field wide enough to hold AXI_BURST_MAX itself.
  localparam int AXI_LEN_W     = 9;
  localparam int AXI_4K_BYTES  = 4096;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_EXOKAY = 2'b01;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  typedef logic [31:0]          addr_32_t;
  typedef logic [63:0]          addr_64_t;
  typedef logic [AXI_LEN_W-1:0] beat_len_t;

  typedef struct packed {
    addr_32_t  start_addr;
    beat_len_t len;
  } trans_32_t;

  typedef struct packed {
    addr_64_t  start_addr;
    beat_len_t len;
  } trans_64_t;

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/mo_burst_split.sv
// -----------------------------------------------------------------------------
// mo_burst_split
// Combinational calculator for the next burst of a large transfer. The burst
// stops at the next 4 KB boundary and is capped at AXI_BURST_MAX beats.
// Shared by the read and write MO FIFOs.
//
// Parameters:
//   ADDR_WIDTH - address width in bits
//   DATA_SHIFT - log2(bytes per beat)
// Ports:
//   cur_addr       in  : current beat-aligned byte address
//   remaining      in  : bytes still to be split (beat multiple)
//   beat_len       out : beats in this burst
//   byte_size      out : bytes in this burst
//   next_addr      out : address following this burst
//   next_remaining out : bytes left after this burst
// -----------------------------------------------------------------------------
module mo_burst_split
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_SHIFT = 5
) (
  input  logic [ADDR_WIDTH-1:0] cur_addr,
  input  logic [31:0]           remaining,
  output beat_len_t             beat_len,
  output logic [31:0]           byte_size,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic [31:0]           next_remaining
);

  localparam logic [31:0] MAX_BYTES = 32'(AXI_BURST_MAX) << DATA_SHIFT;

  // 13 bits: an address sitting exactly on a boundary yields a full 4096.
  logic [12:0] bound;
  logic [31:0] raw_bytes;

  always_comb begin
    bound          = 13'(AXI_4K_BYTES) - {1'b0, cur_addr[11:0]};
    raw_bytes      = min_u32(remaining, {19'd0, bound});
    byte_size      = min_u32(raw_bytes, MAX_BYTES);
    beat_len       = beat_len_t'(byte_size >> DATA_SHIFT);
    next_addr      = cur_addr + ADDR_WIDTH'(byte_size);
    next_remaining = remaining - byte_size;
  end

endmodule

// File: rtl/mo_rd_fifo.sv
// -----------------------------------------------------------------------------
// mo_rd_fifo
// Read-side outstanding-burst FIFO of the AXI DMA. Takes one large read
// request, splits it into 4 KB-safe bursts of at most AXI_BURST_MAX beats,
// keeps up to NUM_MO_BUF bursts outstanding, hands them to the AR driver and
// retires them as the R channel completes each one. rd_done pulses once the
// whole request has been split and every burst has completed.
//
// Optional feature (macro MO_RD_RESP_CHK_EN): adds rd_err, a sticky flag set
// when a burst completes with SLVERR/DECERR, cleared on the next accept.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start_valid/ready : large request handshake
//   start_addr, len   : request byte address (beat aligned) and byte count
//   mo_fifo_full/empty: occupancy flags
//   fifo_mo_ar(_valid/_ready) : descriptor at the AR pointer and handshake
//   fifo_mo_r         : descriptor of the oldest burst receiving data
//   fifo_mo_r_done    : RLAST of the oldest burst accepted
//   fifo_mo_r_resp    : RRESP sampled with fifo_mo_r_done
//   rd_err            : (MO_RD_RESP_CHK_EN only) error seen during request
//   rd_done           : one-cycle completion pulse
//   busy              : not idle
// -----------------------------------------------------------------------------
module mo_rd_fifo
  import axi_pkg::*;
#(
  parameter int  NUM_MO_BUF = 4,
  parameter int  ADDR_WIDTH = 64,
  parameter int  DATA_WIDTH = 256,
  parameter type addr_t     = axi_pkg::addr_64_t,
  parameter type trans_t    = axi_pkg::trans_64_t
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_valid,
  output logic        start_ready,
  input  addr_t       start_addr,
  input  logic [31:0] len,
  output logic        mo_fifo_full,
  output logic        mo_fifo_empty,
  output trans_t      fifo_mo_ar,
  output logic        fifo_mo_ar_valid,
  input  logic        fifo_mo_ar_ready,
  output trans_t      fifo_mo_r,
  input  logic        fifo_mo_r_done,
  input  logic [1:0]  fifo_mo_r_resp,
`ifdef MO_RD_RESP_CHK_EN
  output logic        rd_err,
`endif
  output logic        rd_done,
  output logic        busy
);

  localparam int MO_FIFO_SIZE = NUM_MO_BUF + 1;
  localparam int PTR_W        = (MO_FIFO_SIZE > 2) ? $clog2(MO_FIFO_SIZE) : 1;
  localparam int BPB          = DATA_WIDTH / 8;
  localparam int DATA_SHIFT   = $clog2(BPB);

  localparam logic [31:0]      BEAT_MASK = (32'd1 << DATA_SHIFT) - 32'd1;
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MO_FIFO_SIZE - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SPLIT = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       state_reg, state_next;
  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] ar_ptr_reg, ar_ptr_next;
  logic [PTR_W-1:0] r_ptr_reg, r_ptr_next;
  addr_t            cur_addr_reg, cur_addr_next;
  logic [31:0]      remaining_reg, remaining_next;
  trans_t           fifo_mem [MO_FIFO_SIZE];

  logic full, empty, ar_valid;
  logic accept, push_en, pop_en, ar_fire;

  beat_len_t             split_beats;
  logic [31:0]           split_bytes;
  logic [ADDR_WIDTH-1:0] split_next_addr;
  logic [31:0]           split_next_rem;
  trans_t                push_entry;

  // One slot is kept unused so full and empty are distinguishable from the
  // pointers alone.
  assign full     = (ptr_inc(head_reg) == r_ptr_reg);
  assign empty    = (head_reg == r_ptr_reg);
  assign ar_valid = (ar_ptr_reg != head_reg);

  assign accept  = (state_reg == ST_IDLE) && start_valid && !full;
  assign push_en = (state_reg == ST_SPLIT) && (remaining_reg != 32'd0) && !full;
  // A completion with nothing queued would corrupt the pointers; drop it.
  assign pop_en  = fifo_mo_r_done && !empty;
  assign ar_fire = ar_valid && fifo_mo_ar_ready;

  // ---------------------------------------------------------------------------
  // Burst split calculator
  // ---------------------------------------------------------------------------
  mo_burst_split #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_SHIFT (DATA_SHIFT)
  ) u_split (
    .cur_addr       (cur_addr_reg),
    .remaining      (remaining_reg),
    .beat_len       (split_beats),
    .byte_size      (split_bytes),
    .next_addr      (split_next_addr),
    .next_remaining (split_next_rem)
  );

  always_comb begin
    push_entry            = '0;
    push_entry.start_addr = cur_addr_reg;
    push_entry.len        = split_beats;
  end

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    cur_addr_next  = cur_addr_reg;
    remaining_next = remaining_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next     = ST_SPLIT;
          cur_addr_next  = start_addr;
          // Sub-beat residue of the length is dropped.
          remaining_next = len & ~BEAT_MASK;
        end
      end
      ST_SPLIT: begin
        if (remaining_reg == 32'd0) begin
          state_next = ST_DRAIN;
        end else if (push_en) begin
          cur_addr_next  = addr_t'(split_next_addr);
          remaining_next = split_next_rem;
        end
      end
      ST_DRAIN: begin
        if (empty) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign head_next   = push_en ? ptr_inc(head_reg)   : head_reg;
  assign ar_ptr_next = ar_fire ? ptr_inc(ar_ptr_reg) : ar_ptr_reg;
  assign r_ptr_next  = pop_en  ? ptr_inc(r_ptr_reg)  : r_ptr_reg;

  // Per-slot write strobes. Push and pop never target the same slot because a
  // pop requires a non-empty ring (head != r_ptr).
  logic [MO_FIFO_SIZE-1:0] slot_push;
  logic [MO_FIFO_SIZE-1:0] slot_pop;

  for (genvar gi = 0; gi < MO_FIFO_SIZE; gi++) begin : g_slot_en
    assign slot_push[gi] = push_en && (head_reg  == PTR_W'(gi));
    assign slot_pop[gi]  = pop_en  && (r_ptr_reg == PTR_W'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      head_reg      <= '0;
      ar_ptr_reg    <= '0;
      r_ptr_reg     <= '0;
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
      for (int i = 0; i < MO_FIFO_SIZE; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      state_reg     <= state_next;
      head_reg      <= head_next;
      ar_ptr_reg    <= ar_ptr_next;
      r_ptr_reg     <= r_ptr_next;
      cur_addr_reg  <= cur_addr_next;
      remaining_reg <= remaining_next;
      for (int i = 0; i < MO_FIFO_SIZE; i++) begin
        if (slot_push[i]) begin
          fifo_mem[i] <= push_entry;
        end else if (slot_pop[i]) begin
          // Retired slots read back as zero so fifo_mo_r is clean when idle.
          fifo_mem[i] <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional response error tracking
  // ---------------------------------------------------------------------------
`ifdef MO_RD_RESP_CHK_EN
  logic rd_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_err_reg <= 1'b0;
    end else if (accept) begin
      rd_err_reg <= 1'b0;
    end else if (pop_en && fifo_mo_r_resp[1]) begin
      rd_err_reg <= 1'b1;
    end
  end

  assign rd_err = rd_err_reg;
`else
  logic unused_resp;
  assign unused_resp = ^fifo_mo_r_resp;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign start_ready      = (state_reg == ST_IDLE) && !full;
  assign mo_fifo_full     = full;
  assign mo_fifo_empty    = empty;
  assign fifo_mo_ar_valid = ar_valid;
  assign fifo_mo_ar       = fifo_mem[ar_ptr_reg];
  assign fifo_mo_r        = fifo_mem[r_ptr_reg];
  assign rd_done          = (state_reg == ST_DRAIN) && empty;
  assign busy             = (state_reg != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Protocol checks on the environment
  // ---------------------------------------------------------------------------
  a_rdone_not_issued : assert property (@(posedge clk) disable iff (rst)
    fifo_mo_r_done |-> (r_ptr_reg != ar_ptr_reg));

  a_rdone_empty : assert property (@(posedge clk) disable iff (rst)
    fifo_mo_r_done |-> !empty);

  a_start_aligned : assert property (@(posedge clk) disable iff (rst)
    start_valid |-> ((start_addr & addr_t'(BEAT_MASK)) == '0));

  a_split_nonzero : assert property (@(posedge clk) disable iff (rst)
    push_en |-> (split_bytes != 32'd0));

endmodule

// File: doc/mo_rd_fifo.md
Name: mo_rd_fifo

Overview:
Read-side counterpart of the write MO FIFO in the AXI DMA. Accepts one large read request (address, byte length) and splits it into bursts that never cross a 4 KB boundary and never exceed axi_pkg::AXI_BURST_MAX beats. Queues up to NUM_MO_BUF outstanding bursts. Presents each burst to the AR channel driver, tracks R-channel completion per burst, and pulses rd_done once the whole request has drained.

Parameters:
NUM_MO_BUF, 4, max outstanding bursts (FIFO depth; ring storage NUM_MO_BUF+1)
ADDR_WIDTH, 64, address width (32 or 64)
DATA_WIDTH, 256, AXI data width in bits; bytes per beat BPB = DATA_WIDTH/8, DATA_SHIFT = log2(BPB)
addr_t, axi_pkg::addr_64_t, address type
trans_t, axi_pkg::trans_64_t, burst descriptor {start_addr, len}; len = beat count, 1..AXI_BURST_MAX

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
start_valid  in  1  large request valid
start_ready  out  1  request accepted when valid&&ready
start_addr  in  addr_t  request byte address, BPB-aligned
len  in  32  request bytes; bits [DATA_SHIFT-1:0] ignored
mo_fifo_full  out  1  NUM_MO_BUF entries occupied
mo_fifo_empty  out  1  no entries occupied
fifo_mo_ar  out  trans_t  descriptor at AR pointer
fifo_mo_ar_valid  out  1  unissued descriptor present
fifo_mo_ar_ready  in  1  AR driver took descriptor
fifo_mo_r  out  trans_t  descriptor at R (pop) pointer, i.e. oldest burst receiving data
fifo_mo_r_done  in  1  single-cycle pulse: RLAST beat of oldest burst accepted
fifo_mo_r_resp  in  2  RRESP sampled with r_done (used only with optional feature)
rd_done  out  1  one-cycle pulse: request fully split and all bursts completed
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port rst.
- Reset values:
  - state=IDLE; head, ar_ptr, r_ptr = 0; cur_addr = 0; remaining = 0; all fifo_mem entries = '{0,0}.
  - Outputs: start_ready=1, mo_fifo_empty=1, mo_fifo_full=0, ar_valid=0, rd_done=0, busy=0, fifo_mo_ar/fifo_mo_r = '{0,0}.
- Reset mid-operation: all of the above is restored immediately. In-flight bursts are discarded and no rd_done is produced.
- Ring storage is MO_FIFO_SIZE = NUM_MO_BUF+1 entries; pointers wrap from MO_FIFO_SIZE-1 to 0.
  - full = (head+1 mod SIZE) == r_ptr
  - empty = head == r_ptr
  - ar_valid = ar_ptr != head
- States:
  - IDLE: start_ready = !full. On accept, load cur_addr=start_addr and remaining = len with low DATA_SHIFT bits cleared, then go to SPLIT.
  - SPLIT: each cycle with remaining>0 && !full, push one descriptor.
    - bound = 4096 - cur_addr[11:0] (13 bits)
    - raw = min(remaining, bound)
    - bytes = min(raw, AXI_BURST_MAX<<DATA_SHIFT)
    - write fifo_mem[head] = {cur_addr, bytes>>DATA_SHIFT}; head++; cur_addr += bytes; remaining -= bytes.
    - When remaining==0 (including a zero-length request), go to DRAIN.
  - DRAIN: when empty, pulse rd_done for one cycle and return to IDLE.
- Latency:
  - Accept at cycle T gives first push at T+1 and ar_valid at T+2 (if not full).
  - Zero-length request: rd_done at T+2.
- Pointer advance:
  - ar_ptr advances on ar_valid && ar_ready.
  - On fifo_mo_r_done, fifo_mem[r_ptr] is cleared to '{0,0} and r_ptr advances.
- Simultaneous events:
  - Push and r_done pop in the same cycle are legal. full/empty reflect registered pointers, so a pop does not free a slot until the next cycle.
  - ar handshake and r_done in the same cycle are legal.
- Illegal inputs (simulation assertions, RTL ignores them):
  - r_done while r_ptr == ar_ptr (burst not yet issued).
  - r_done while empty.
  - start_valid with misaligned start_addr.

Optional Feature:
MO_RD_RESP_CHK_EN:
- Defined: adds output rd_err (1 bit), reset 0.
  - Set sticky when r_done coincides with fifo_mo_r_resp[1]==1 (SLVERR/DECERR).
  - Cleared on the next request accept.
  - Valid together with the rd_done pulse.
- Undefined: rd_err port and logic absent; fifo_mo_r_resp is unused.

Decomposition:
- axi_pkg holds: addr_32_t/addr_64_t, trans_32_t/trans_64_t, AXI_BURST_MAX, 4 KB boundary constant, RRESP encodings.
- One natural sub-module: mo_burst_split, the combinational split calculator.
  - Inputs: cur_addr, remaining.
  - Outputs: beat len, byte size, next addr, next remaining.
  - Shared later with mo_wr_fifo.

Test Plan:
- addr 0x0FC0, len 0x100, ar_ready=1 -> descriptors {0x0FC0,2}, {0x1000,6}; rd_done 1 cycle after second r_done.
- addr 0x0, len 8192 -> {0x0,128}, {0x1000,128}; exactly 2 pushes.
- NUM_MO_BUF=4, addr 0, len 5*4096, no r_done -> 4 pushes; full=1, start_ready=0, 5th push held; one r_done -> 5th push {0x4000,128} on the following cycle.
- len=0 accepted -> no ar_valid; rd_done at T+2; busy drops afterwards.
- Reset asserted in SPLIT with 2 entries outstanding -> empty=1, ar_valid=0, start_ready=1 immediately; no rd_done.
- MO_RD_RESP_CHK_EN defined, second of three r_done carries resp=2'b10 -> rd_err=1 at rd_done; cleared on the next accept.
